// File: rtl/risc_v_processor_pkg.sv
// Shared definitions for the single-cycle RV64I subset core: opcodes, ALU
// operation codes, the ALU class encoding and the main-control bundle.
package risc_v_processor_pkg;

   // Supported opcodes; anything else executes as a NOP.
   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;

   // ALU operation codes driven by ALU control.
   localparam logic [3:0] AluAnd = 4'b0000;
   localparam logic [3:0] AluOr  = 4'b0001;
   localparam logic [3:0] AluAdd = 4'b0010;
   localparam logic [3:0] AluSub = 4'b0110;

   typedef enum logic [1:0] {
      AluOpAdd   = 2'b00,
      AluOpSub   = 2'b01,
      AluOpFunct = 2'b10
   } alu_op_e;

   typedef struct packed {
      logic    alu_src;
      logic    mem_to_reg;
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    branch;
      alu_op_e alu_op;
   } ctrl_t;

endpackage

// File: rtl/risc_v_processor_alu.sv
// 64-bit ALU, wrap-around arithmetic, no overflow flag.
//   a_i, b_i : operands
//   op_i     : operation code
//   result_o : result; zero_o set when result is 0
module risc_v_processor_alu
   import risc_v_processor_pkg::*;
(
   input  logic [63:0] a_i,
   input  logic [63:0] b_i,
   input  logic [3:0]  op_i,
   output logic [63:0] result_o,
   output logic        zero_o
);

   always_comb begin
      result_o = a_i + b_i;
      case (op_i)
         AluAnd:  result_o = a_i & b_i;
         AluOr:   result_o = a_i | b_i;
         AluSub:  result_o = a_i - b_i;
         default: result_o = a_i + b_i;
      endcase
   end

   assign zero_o = (result_o == 64'd0);

endmodule

// File: rtl/risc_v_processor_alu_control.sv
// ALU control: maps ALU class plus funct fields to an ALU operation code.
//   alu_op_i    : class from main control
//   funct7_5_i  : instruction[30]
//   funct3_i    : instruction[14:12]
//   operation_o : ALU operation
module risc_v_processor_alu_control
   import risc_v_processor_pkg::*;
(
   input  alu_op_e    alu_op_i,
   input  logic       funct7_5_i,
   input  logic [2:0] funct3_i,
   output logic [3:0] operation_o
);

   always_comb begin
      operation_o = AluAdd;
      case (alu_op_i)
         AluOpAdd: operation_o = AluAdd;
         AluOpSub: operation_o = AluSub;
         AluOpFunct: begin
            case ({funct7_5_i, funct3_i})
               4'b0000: operation_o = AluAdd;
               4'b1000: operation_o = AluSub;
               4'b0111: operation_o = AluAnd;
               4'b0110: operation_o = AluOr;
               default: operation_o = AluAdd;
            endcase
         end
         default: operation_o = AluAdd;
      endcase
   end

endmodule

// File: rtl/risc_v_processor_control.sv
// Main control decoder.
//   opcode_i : instruction[6:0]
//   ctrl_o   : control bundle; all zero for unsupported opcodes (NOP)
module risc_v_processor_control
   import risc_v_processor_pkg::*;
(
   input  logic [6:0] opcode_i,
   output ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (opcode_i)
         OpR: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_op    = AluOpFunct;
         end
         OpImm: begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.reg_write = 1'b1;
         end
         OpLoad: begin
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_read   = 1'b1;
         end
         OpStore: begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.mem_write = 1'b1;
         end
         OpBranch: begin
            ctrl_o.branch = 1'b1;
            ctrl_o.alu_op = AluOpSub;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/risc_v_processor_dmem.sv
// 64-byte little-endian data memory accessed as doublewords.
//   clk_i, rst_ni : clock, synchronous active-low clear to zero
//   addr_i        : byte address; accesses wrap within 64 bytes
//   we_i, wdata_i : doubleword write on the rising edge
//   rdata_o       : combinational doubleword read
module risc_v_processor_dmem (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [5:0]  addr_i,
   input  logic        we_i,
   input  logic [63:0] wdata_i,
   output logic [63:0] rdata_o
);

   logic [7:0] mem [64];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < 64; i++) begin
            mem[i] <= '0;
         end
      end else if (we_i) begin
         for (int i = 0; i < 8; i++) begin
            mem[addr_i + 6'(i)] <= wdata_i[8*i +: 8];
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      for (int i = 0; i < 8; i++) begin
         rdata_o[8*i +: 8] = mem[addr_i + 6'(i)];
      end
   end

endmodule

// File: rtl/risc_v_processor_imem.sv
// 64-byte little-endian instruction ROM holding the fixed program.
//   addr_i  : byte address (wraps within 64 bytes)
//   instr_o : 32-bit instruction assembled from four consecutive bytes
module risc_v_processor_imem (
   input  logic [5:0]  addr_i,
   output logic [31:0] instr_o
);

   function automatic logic [31:0] prog_word(input logic [3:0] idx);
      case (idx)
         4'd0:    return 32'h0050_0093; // addi x1,x0,5
         4'd1:    return 32'h0030_0113; // addi x2,x0,3
         4'd2:    return 32'h0020_81b3; // add  x3,x1,x2
         4'd3:    return 32'h4020_8233; // sub  x4,x1,x2
         4'd4:    return 32'h0030_3023; // sd   x3,0(x0)
         4'd5:    return 32'h0000_3283; // ld   x5,0(x0)
         4'd6:    return 32'h0032_8463; // beq  x5,x3,+8
         4'd7:    return 32'h0010_0313; // addi x6,x0,1
         4'd8:    return 32'h0020_e3b3; // or   x7,x1,x2
         4'd9:    return 32'h0000_0063; // beq  x0,x0,0
         default: return 32'h0000_0000;
      endcase
   endfunction

   function automatic logic [7:0] rom_byte(input logic [5:0] a);
      logic [31:0] w;
      w = prog_word(a[5:2]);
      return w[{a[1:0], 3'b000} +: 8];
   endfunction

   assign instr_o = {rom_byte(addr_i + 6'd3), rom_byte(addr_i + 6'd2),
                     rom_byte(addr_i + 6'd1), rom_byte(addr_i)};

endmodule

// File: rtl/risc_v_processor_imm_gen.sv
// Sign-extending immediate generator. The B-type immediate is left in
// halfword units; the top shifts it to form the byte offset.
//   instr_i : instruction
//   imm_o   : 64-bit sign-extended immediate (0 for non I/S/B opcodes)
module risc_v_processor_imm_gen
   import risc_v_processor_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic [63:0] imm_o
);

   logic unused_fields;
   assign unused_fields = ^instr_i[19:12];

   always_comb begin
      imm_o = '0;
      case (instr_i[6:0])
         OpImm, OpLoad: imm_o = {{52{instr_i[31]}}, instr_i[31:20]};
         OpStore:       imm_o = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         OpBranch:      imm_o = {{52{instr_i[31]}}, instr_i[31], instr_i[7],
                                 instr_i[30:25], instr_i[11:8]};
         default:       imm_o = '0;
      endcase
   end

endmodule

// File: rtl/risc_v_processor_pc.sv
// Program counter register.
//   clk_i     : clock
//   rst_ni    : synchronous active-low reset, clears PC to 0
//   pc_next_i : value loaded every rising edge
//   pc_o      : current PC
module risc_v_processor_pc (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [63:0] pc_next_i,
   output logic [63:0] pc_o
);

   logic [63:0] pc_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_next_i;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/risc_v_processor_regfile.sv
// 32 x 64-bit register file, two combinational reads, one synchronous write.
//   clk_i, rst_ni      : clock, synchronous active-low clear of all registers
//   rs1_i, rs2_i       : read addresses; x0 always reads 0
//   rd_i, we_i, wdata_i: write port, ignored for rd=0
//   rdata1_o, rdata2_o : read data
module risc_v_processor_regfile (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [4:0]  rd_i,
   input  logic        we_i,
   input  logic [63:0] wdata_i,
   output logic [63:0] rdata1_o,
   output logic [63:0] rdata2_o
);

   logic [63:0] regs [32];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (we_i && (rd_i != 5'd0)) begin
         regs[rd_i] <= wdata_i;
      end
   end

   assign rdata1_o = (rs1_i == 5'd0) ? '0 : regs[rs1_i];
   assign rdata2_o = (rs2_i == 5'd0) ? '0 : regs[rs2_i];

endmodule

// File: rtl/risc_v_processor.sv
// Single-cycle RV64I subset core (add, sub, and, or, addi, ld, sd, beq).
// Ports: clk, reset (synchronous, active low); every datapath and control
// node is exported for observation: PC_In/PC_Out, instruction and its
// fields, register-file reads and write-back, control outputs, ALU
// operands/result/Zero, immediate, branch target and data-memory read.
module risc_v_processor
   import risc_v_processor_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic [63:0] PC_In,
   output logic [63:0] PC_Out,
   output logic [31:0] instruction,
   output logic [6:0]  opcode,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [63:0] WriteData,
   output logic [63:0] ReadData1,
   output logic [63:0] ReadData2,
   output logic        Branch,
   output logic        MemWrite,
   output logic        MemRead,
   output logic        MemtoReg,
   output logic        ALUSrc,
   output logic        RegWrite,
   output logic [1:0]  ALUOp,
   output logic [63:0] Result,
   output logic [63:0] read_mem_data,
   output logic [63:0] imm,
   output logic [3:0]  operation,
   output logic        Zero,
   output logic [63:0] ALU_input2,
   output logic [63:0] branch,
   output logic [63:0] immi
);

   ctrl_t ctrl;

   risc_v_processor_pc u_pc (
      .clk_i     (clk),
      .rst_ni    (reset),
      .pc_next_i (PC_In),
      .pc_o      (PC_Out)
   );

   risc_v_processor_imem u_imem (
      .addr_i  (PC_Out[5:0]),
      .instr_o (instruction)
   );

   assign opcode = instruction[6:0];
   assign rs1    = instruction[19:15];
   assign rs2    = instruction[24:20];
   assign rd     = instruction[11:7];

   risc_v_processor_control u_control (
      .opcode_i (opcode),
      .ctrl_o   (ctrl)
   );

   assign Branch   = ctrl.branch;
   assign MemWrite = ctrl.mem_write;
   assign MemRead  = ctrl.mem_read;
   assign MemtoReg = ctrl.mem_to_reg;
   assign ALUSrc   = ctrl.alu_src;
   assign RegWrite = ctrl.reg_write;
   assign ALUOp    = ctrl.alu_op;

   risc_v_processor_regfile u_regfile (
      .clk_i    (clk),
      .rst_ni   (reset),
      .rs1_i    (rs1),
      .rs2_i    (rs2),
      .rd_i     (rd),
      .we_i     (RegWrite),
      .wdata_i  (WriteData),
      .rdata1_o (ReadData1),
      .rdata2_o (ReadData2)
   );

   risc_v_processor_imm_gen u_imm_gen (
      .instr_i (instruction),
      .imm_o   (imm)
   );

   risc_v_processor_alu_control u_alu_control (
      .alu_op_i    (ctrl.alu_op),
      .funct7_5_i  (instruction[30]),
      .funct3_i    (instruction[14:12]),
      .operation_o (operation)
   );

   assign ALU_input2 = ALUSrc ? imm : ReadData2;

   risc_v_processor_alu u_alu (
      .a_i      (ReadData1),
      .b_i      (ALU_input2),
      .op_i     (operation),
      .result_o (Result),
      .zero_o   (Zero)
   );

   risc_v_processor_dmem u_dmem (
      .clk_i   (clk),
      .rst_ni  (reset),
      .addr_i  (Result[5:0]),
      .we_i    (MemWrite),
      .wdata_i (ReadData2),
      .rdata_o (read_mem_data)
   );

   assign WriteData = MemtoReg ? read_mem_data : Result;

   // B-type immediate is in halfwords; convert to a byte offset.
   assign immi   = {imm[62:0], 1'b0};
   assign branch = PC_Out + immi;
   assign PC_In  = (Branch && Zero) ? branch : (PC_Out + 64'd4);

endmodule

// File: tb/tb_risc_v_processor.sv
module tb_risc_v_processor;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] PC_In, PC_Out, WriteData, ReadData1, ReadData2, Result;
   logic [63:0] read_mem_data, imm, ALU_input2, branch, immi;
   logic [31:0] instruction;
   logic [6:0]  opcode;
   logic [4:0]  rs1, rs2, rd;
   logic        Branch, MemWrite, MemRead, MemtoReg, ALUSrc, RegWrite, Zero;
   logic [1:0]  ALUOp;
   logic [3:0]  operation;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   risc_v_processor dut (
      .clk           (clk),
      .reset         (reset),
      .PC_In         (PC_In),
      .PC_Out        (PC_Out),
      .instruction   (instruction),
      .opcode        (opcode),
      .rs1           (rs1),
      .rs2           (rs2),
      .rd            (rd),
      .WriteData     (WriteData),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2),
      .Branch        (Branch),
      .MemWrite      (MemWrite),
      .MemRead       (MemRead),
      .MemtoReg      (MemtoReg),
      .ALUSrc        (ALUSrc),
      .RegWrite      (RegWrite),
      .ALUOp         (ALUOp),
      .Result        (Result),
      .read_mem_data (read_mem_data),
      .imm           (imm),
      .operation     (operation),
      .Zero          (Zero),
      .ALU_input2    (ALU_input2),
      .branch        (branch),
      .immi          (immi)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference ISA model: program image, architectural state, per-cycle expectations.
   logic [31:0] prog [16];
   logic [63:0] m_pc;
   logic [63:0] m_x [32];
   logic [7:0]  m_mem [64];
   logic [31:0] e_inst;
   logic [63:0] e_result, e_pc_in, e_wval, e_store;
   logic        e_wr, e_st, e_br;

   function automatic logic [31:0] fetch(input logic [63:0] pc);
      logic [31:0] r;
      logic [31:0] w;
      logic [5:0]  a;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         a = pc[5:0] + 6'(i);
         w = prog[a[5:2]];
         r[8*i +: 8] = w[8*int'(a[1:0]) +: 8];
      end
      return r;
   endfunction

   function automatic logic [63:0] m_load(input logic [5:0] a);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = m_mem[a + 6'(i)];
      return r;
   endfunction

   task automatic model_eval();
      logic [63:0] a, b, imm_i, imm_s, imm_b;
      e_inst = fetch(m_pc);
      a = m_x[e_inst[19:15]];
      b = m_x[e_inst[24:20]];
      imm_i = {{52{e_inst[31]}}, e_inst[31:20]};
      imm_s = {{52{e_inst[31]}}, e_inst[31:25], e_inst[11:7]};
      imm_b = {{51{e_inst[31]}}, e_inst[31], e_inst[7], e_inst[30:25], e_inst[11:8], 1'b0};
      e_pc_in = m_pc + 64'd4;
      e_result = a + b;
      e_wr = 1'b0; e_st = 1'b0; e_br = 1'b0;
      e_wval = '0; e_store = b;
      case (e_inst[6:0])
         7'b0110011: begin
            case ({e_inst[30], e_inst[14:12]})
               4'b1000: e_result = a - b;
               4'b0111: e_result = a & b;
               4'b0110: e_result = a | b;
               default: e_result = a + b;
            endcase
            e_wr = 1'b1; e_wval = e_result;
         end
         7'b0010011: begin e_result = a + imm_i; e_wr = 1'b1; e_wval = e_result; end
         7'b0000011: begin
            e_result = a + imm_i; e_wr = 1'b1; e_wval = m_load(e_result[5:0]);
         end
         7'b0100011: begin e_result = a + imm_s; e_st = 1'b1; end
         7'b1100011: begin
            e_result = a - b; e_br = 1'b1;
            if (a == b) e_pc_in = m_pc + imm_b;
         end
         default: ;
      endcase
   endtask

   task automatic model_commit(input logic rst_n);
      if (!rst_n) begin
         m_pc = '0;
         foreach (m_x[i]) m_x[i] = '0;
         foreach (m_mem[i]) m_mem[i] = '0;
      end else begin
         if (e_st) for (int i = 0; i < 8; i++) m_mem[e_result[5:0] + 6'(i)] = e_store[8*i +: 8];
         if (e_wr && e_inst[11:7] != 5'd0) m_x[e_inst[11:7]] = e_wval;
         m_pc = e_pc_in;
      end
   endtask

   function automatic logic [63:0] dut_dword0();
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = dut.u_dmem.mem[i];
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [63:0] any_set;
      logic        nrst;
      prog = '{32'h00500093, 32'h00300113, 32'h002081b3, 32'h40208233,
               32'h00303023, 32'h00003283, 32'h00328463, 32'h00100313,
               32'h0020e3b3, 32'h00000063, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

      // Reset held for two edges.
      @(posedge clk); @(posedge clk); @(negedge clk);
      check_eq("reset_pc", PC_Out, 64'd0);
      check_eq("reset_instr", {32'd0, instruction}, 64'h00500093);
      any_set = '0;
      for (int i = 0; i < 32; i++) any_set |= dut.u_regfile.regs[i];
      check_eq("reset_regs", any_set, 64'd0);
      reset = 1'b1;

      step(); step(); step();
      check_eq("pc12", PC_Out, 64'd12);
      check_eq("sub_op", {60'd0, operation}, 64'h6);
      check_eq("sub_result", Result, 64'd2);
      step();
      check_eq("x1", dut.u_regfile.regs[1], 64'd5);
      check_eq("x2", dut.u_regfile.regs[2], 64'd3);
      check_eq("x3", dut.u_regfile.regs[3], 64'd8);
      check_eq("x4", dut.u_regfile.regs[4], 64'd2);
      check_eq("sd_memwrite", {63'd0, MemWrite}, 64'd1);
      step();
      check_eq("ld_memread", {63'd0, MemRead}, 64'd1);
      check_eq("mem_dword0", dut_dword0(), 64'd8);
      check_eq("read_mem_data", read_mem_data, 64'd8);
      step();
      check_eq("x5", dut.u_regfile.regs[5], 64'd8);
      check_eq("beq_zero", {63'd0, Zero}, 64'd1);
      check_eq("beq_immi", immi, 64'd8);
      check_eq("beq_target", branch, 64'd32);
      check_eq("beq_pc_in", PC_In, 64'd32);
      step();
      check_eq("pc32", PC_Out, 64'd32);
      check_eq("x6", dut.u_regfile.regs[6], 64'd0);
      step();
      check_eq("x7", dut.u_regfile.regs[7], 64'd7);
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("halt_pc", PC_Out, 64'd36);
      end

      // One-edge reset pulse mid-program.
      reset = 1'b0;
      step();
      reset = 1'b1;
      check_eq("pulse_pc", PC_Out, 64'd0);
      any_set = '0;
      for (int i = 1; i < 8; i++) any_set |= dut.u_regfile.regs[i];
      check_eq("pulse_regs", any_set, 64'd0);

      // Random reset schedule against the reference model.
      model_commit(1'b0);
      for (int c = 0; c < 300; c++) begin
         model_eval();
         check_eq("pc", PC_Out, m_pc);
         check_eq("instr", {32'd0, instruction}, {32'd0, e_inst});
         check_eq("result", Result, e_result);
         check_eq("zero", {63'd0, Zero}, {63'd0, (e_result == 64'd0)});
         check_eq("pc_in", PC_In, e_pc_in);
         check_eq("regwrite", {63'd0, RegWrite}, {63'd0, e_wr});
         check_eq("memwrite", {63'd0, MemWrite}, {63'd0, e_st});
         check_eq("branch_ctl", {63'd0, Branch}, {63'd0, e_br});
         if (e_wr) check_eq("writedata", WriteData, e_wval);
         for (int i = 1; i < 8; i++) check_eq($sformatf("x%0d", i), dut.u_regfile.regs[i], m_x[i]);
         check_eq("dmem0", dut_dword0(), m_load(6'd0));
         nrst = ($urandom_range(0, 19) != 0);
         reset = nrst;
         @(posedge clk);
         model_commit(nrst);
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/risc_v_processor.md
RISC_V_PROCESSOR -- requirements
Module: risc_v_processor

Interface
REQ-001 The module SHALL expose these ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- PC_In  out  64  next-PC value loaded into PC at next edge.
- PC_Out  out  64  current PC register (fetch address).
- instruction  out  32  fetched instruction.
- opcode  out  7  instruction[6:0].
- rs1, rs2, rd  out  5 each  instruction[19:15], [24:20], [11:7].
- WriteData  out  64  register-file write-back value.
- ReadData1, ReadData2  out  64 each  register-file reads of rs1/rs2; ReadData2 is the store data.
- Branch, MemWrite, MemRead, MemtoReg, ALUSrc, RegWrite  out  1 each  main-control outputs.
- ALUOp  out  2  main-control ALU class.
- Result  out  64  ALU result; also the data-memory address.
- read_mem_data  out  64  data-memory read value.
- imm  out  64  sign-extended immediate.
- operation  out  4  ALU control code.
- Zero  out  1  Result == 0.
- ALU_input2  out  64  ALU B operand (ALUSrc mux output).
- branch  out  64  branch target, PC_Out + immi.
- immi  out  64  imm shifted left 1.

Function
REQ-002 The design SHALL be a single-cycle RV64I subset executing add, sub, and, or, addi, ld, sd and beq; every other opcode SHALL behave as a NOP (all control outputs 0, PC += 4).
REQ-003 Instruction memory SHALL be 64 bytes, byte-addressed, little-endian, read combinationally at PC_Out[5:0], and preloaded with the program in REQ-016.
REQ-004 Data memory SHALL be 64 bytes, little-endian, holding 8-byte doublewords.
- Read: combinational at Result[5:0].
- Write: ReadData2 written on the rising edge when MemWrite=1.
- Reset: zero.
REQ-005 The register file SHALL hold 32x64 registers.
- Reads: combinational.
- Write: WriteData written on the rising edge when RegWrite=1 and rd!=0.
- x0: always reads 0.
REQ-006 Main control by opcode (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp):
- R 0110011: 0, 0, 1, 0, 0, 0, 10
- addi 0010011: 1, 0, 1, 0, 0, 0, 00
- ld 0000011: 1, 1, 1, 1, 0, 0, 00
- sd 0100011: 1, x, 0, 0, 1, 0, 00
- beq 1100011: 0, x, 0, 0, 0, 1, 01
REQ-007 ALU control SHALL produce operation as follows:
- ALUOp 00 -> 0010 (add).
- ALUOp 01 -> 0110 (sub).
- ALUOp 10 with {funct7[5], funct3}:
  - 0000 -> 0010 (add)
  - 1000 -> 0110 (sub)
  - 0111 -> 0000 (and)
  - 0110 -> 0001 (or)
REQ-008 The ALU SHALL compute 64-bit AND/OR/ADD/SUB with wrap-around and no overflow flag; Zero=1 iff Result==0.
REQ-009 Immediate generation SHALL sign-extend from instruction[31]:
- I-type: [31:20].
- S-type: {[31:25],[11:7]}.
- B-type: {[31],[7],[30:25],[11:8]}, an offset in halfword units.
- Others: 0.
REQ-010 ALU_input2 SHALL be imm when ALUSrc=1, else ReadData2.
REQ-011 WriteData SHALL be read_mem_data when MemtoReg=1, else Result.
REQ-012 PC_In SHALL be branch when (Branch & Zero), else PC_Out+4; the PC SHALL update every cycle with no stall.

Reset
REQ-013 While reset=0 at a rising edge, the PC, all 32 registers and data memory SHALL clear to 0, and no writes from the current instruction SHALL occur.
REQ-014 The first instruction after reset SHALL be fetched from address 0 in the cycle following reset release; reset asserted mid-program SHALL restart at 0 with cleared state.

Structure
REQ-015 Opcode constants and ALU operation codes SHALL live in a shared package. Natural sub-modules are: pc register, instruction_memory, register_file, imm_gen, control_unit, alu_control, alu and data_memory; the top SHALL only wire them.
REQ-016 The preloaded program SHALL be:
- 0: addi x1,x0,5
- 4: addi x2,x0,3
- 8: add x3,x1,x2
- 12: sub x4,x1,x2
- 16: sd x3,0(x0)
- 20: ld x5,0(x0)
- 24: beq x5,x3,+8
- 28: addi x6,x0,1
- 32: or x7,x1,x2
- 36: beq x0,x0,0 (halt loop)

Verification
REQ-017 Hold reset=0 for 2 edges -> PC_Out=0, instruction=addi x1 encoding, all registers 0.
REQ-018 Run 4 cycles after release -> x1=5, x2=3, x3=8, x4=2; at PC 12, operation=0110 and Result=2.
REQ-019 sd/ld at PC 16/20 -> MemWrite=1 then MemRead=1; memory bytes 0..7 hold 8; x5=8; read_mem_data=8.
REQ-020 beq at PC 24 -> Zero=1, immi=8, branch=32, PC_In=32; x6 remains 0.
REQ-021 Halt at PC 36 -> x7=7, PC_Out stays 36 for 5 further cycles; reset pulsed low for one edge -> PC_Out=0 and x1..x7=0.
